// File: rtl/lap_time_text_gen_if.sv
// rtl/lap_time_text_gen_if.sv - conversion handshake and character lookup bus for the lap-time text line
interface lap_time_text_gen_if #(
  parameter int TIME_W = 16
);
  logic              start;
  logic [TIME_W-1:0] time_in;
  logic [1:0]        mode;
  logic [15:0]       char_xy;
  logic [6:0]        char_code;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, time_in, mode, char_xy,
    input  char_code, busy, done, ovf
  );

  modport slave (
    input  start, time_in, mode, char_xy,
    output char_code, busy, done, ovf
  );
endinterface

// File: rtl/lap_time_text_gen.sv
// rtl/lap_time_text_gen.sv - lap time (centiseconds) to M:SS:CC text line for the HUD character renderer
module lap_time_text_gen #(
  parameter int TIME_W     = 16,
  parameter int MIN_DIGITS = 1,
  parameter int ROW        = 0
) (
  input logic               pclk,
  input logic               rst_n,
  lap_time_text_gen_if.slave bus
);

  localparam int RW = (TIME_W > 19) ? TIME_W : 19;
  localparam longint unsigned CAP     = (64'd1 << TIME_W) - 64'd1;
  localparam longint unsigned MAX_RAW = (MIN_DIGITS == 2) ? 64'd359999 : 64'd59999;
  localparam longint unsigned MAX_L   = (MAX_RAW < CAP) ? MAX_RAW : CAP;
  localparam logic [RW-1:0] MAX   = RW'(MAX_L);
  localparam logic [RW-1:0] K_MIN = RW'(6000);
  localparam logic [RW-1:0] K_SEC = RW'(100);
  localparam logic [RW-1:0] K_CS  = RW'(10);
  localparam logic [7:0]    ROW_B = ROW[7:0];
  localparam logic [103:0]  L_BEST = "BEST LAP TIME";
  localparam logic [103:0]  L_LAST = "LAST LAP TIME";
  localparam logic [103:0]  L_LAP  = "LAP TIME     ";

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MIN, S_SEC, S_CS, S_COMMIT} state_t;

  state_t            state;
  logic [TIME_W-1:0] tin;
  logic [TIME_W-1:0] pend_val;
  logic              pend;
  logic [RW-1:0]     rem;
  logic              ovf_work;
  logic [7:0]        w_min, w_sec;
  logic [3:0]        w_cs_t, w_cs_o;
  logic [7:0]        c_min, c_sec;
  logic [3:0]        c_cs_t, c_cs_o;
  logic              valid;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.ovf  <= 1'b0;
      tin      <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      rem      <= '0;
      ovf_work <= 1'b0;
      w_min    <= '0;
      w_sec    <= '0;
      w_cs_t   <= '0;
      w_cs_o   <= '0;
      c_min    <= '0;
      c_sec    <= '0;
      c_cs_t   <= '0;
      c_cs_o   <= '0;
      valid    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.start && state != S_IDLE) begin
        pend     <= 1'b1;
        pend_val <= bus.time_in;
      end
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            tin      <= bus.time_in;
            state    <= S_LOAD;
            bus.busy <= 1'b1;
          end
        end
        S_LOAD: begin
          ovf_work <= (RW'(tin) > MAX);
          rem      <= (RW'(tin) > MAX) ? MAX : RW'(tin);
          w_min    <= '0;
          w_sec    <= '0;
          w_cs_t   <= '0;
          w_cs_o   <= '0;
          state    <= S_MIN;
        end
        S_MIN: begin
          if (rem >= K_MIN) begin
            rem   <= rem - K_MIN;
            w_min <= bcd_inc(w_min);
          end else begin
            state <= S_SEC;
          end
        end
        S_SEC: begin
          if (rem >= K_SEC) begin
            rem   <= rem - K_SEC;
            w_sec <= bcd_inc(w_sec);
          end else begin
            state <= S_CS;
          end
        end
        S_CS: begin
          if (rem >= K_CS) begin
            rem    <= rem - K_CS;
            w_cs_t <= w_cs_t + 4'd1;
          end else begin
            w_cs_o <= rem[3:0];
            state  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          c_min    <= w_min;
          c_sec    <= w_sec;
          c_cs_t   <= w_cs_t;
          c_cs_o   <= w_cs_o;
          bus.ovf  <= ovf_work;
          valid    <= 1'b1;
          bus.done <= 1'b1;
          // A start arriving in this very cycle is newer than anything already pending.
          if (pend || bus.start) begin
            tin   <= bus.start ? bus.time_in : pend_val;
            pend  <= 1'b0;
            state <= S_LOAD;
          end else begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [6:0] label_char(input logic [1:0] m, input logic [7:0] c);
    int sh;
    sh = 8 * (12 - int'(c));
    case (m)
      2'd0:    return L_BEST[sh +: 7];
      2'd1:    return L_LAST[sh +: 7];
      default: return L_LAP[sh +: 7];
    endcase
  endfunction

  function automatic logic [6:0] digit_char(input logic [3:0] d, input logic v);
    return v ? {3'b011, d} : 7'h2D;
  endfunction

  logic [6:0] lut;
  logic [7:0] col;
  logic [7:0] idx;

  // idx walks the fixed tail "MM:SS:CC"; single-digit minutes skip the tens slot.
  always_comb begin
    lut = 7'h00;
    col = bus.char_xy[15:8];
    idx = col - 8'd15 + ((MIN_DIGITS == 2) ? 8'd0 : 8'd1);
    if (bus.char_xy[7:0] == ROW_B) begin
      if (col < 8'd13)       lut = label_char(bus.mode, col);
      else if (col == 8'd13) lut = 7'h3A;
      else if (col == 8'd14) lut = 7'h20;
      else begin
        case (idx)
          8'd0:    lut = digit_char(c_min[7:4], valid);
          8'd1:    lut = digit_char(c_min[3:0], valid);
          8'd2:    lut = 7'h3A;
          8'd3:    lut = digit_char(c_sec[7:4], valid);
          8'd4:    lut = digit_char(c_sec[3:0], valid);
          8'd5:    lut = 7'h3A;
          8'd6:    lut = digit_char(c_cs_t, valid);
          8'd7:    lut = digit_char(c_cs_o, valid);
          default: lut = 7'h00;
        endcase
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) bus.char_code <= 7'h00;
    else        bus.char_code <= lut;
  end

endmodule

// File: tb/tb_lap_time_text_gen.sv
// tb/tb_lap_time_text_gen.sv - directed self-checking bench for lap_time_text_gen
module tb_lap_time_text_gen;

  logic pclk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 pclk = ~pclk;

  lap_time_text_gen_if #(.TIME_W(16)) i1();
  lap_time_text_gen_if #(.TIME_W(20)) i2();

  lap_time_text_gen #(.TIME_W(16), .MIN_DIGITS(1), .ROW(0)) d1 (
    .pclk(pclk), .rst_n(rst_n), .bus(i1)
  );
  lap_time_text_gen #(.TIME_W(20), .MIN_DIGITS(2), .ROW(3)) d2 (
    .pclk(pclk), .rst_n(rst_n), .bus(i2)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic read1(input logic [7:0] row, input int c0, input int n, output string s);
    s = "";
    for (int c = 0; c < n; c++) begin
      i1.char_xy = {8'(c0 + c), row};
      tick();
      s = $sformatf("%s%c", s, i1.char_code);
    end
  endtask

  task automatic read2(input logic [7:0] row, input int c0, input int n, output string s);
    s = "";
    for (int c = 0; c < n; c++) begin
      i2.char_xy = {8'(c0 + c), row};
      tick();
      s = $sformatf("%s%c", s, i2.char_code);
    end
  endtask

  task automatic run1(input logic [15:0] t, input int max, output int lat);
    i1.start = 1'b1;
    i1.time_in = t;
    tick();
    i1.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= max; n++) begin
      tick();
      if (i1.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run2(input logic [19:0] t, input int max, output int lat);
    i2.start = 1'b1;
    i2.time_in = t;
    tick();
    i2.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= max; n++) begin
      tick();
      if (i2.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    string s;
    rst_n = 1'b0;
    i1.start = 1'b0; i1.time_in = '0; i1.mode = 2'd0; i1.char_xy = 16'h0F00;
    i2.start = 1'b0; i2.time_in = '0; i2.mode = 2'd0; i2.char_xy = 16'h0F03;
    repeat (3) tick();
    checks++;
    if (i1.char_code !== 7'h00) $display("FAIL reset_char_code: got %h expected 00", i1.char_code);
    else passes++;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({i1.busy, i1.done, i1.ovf} !== 3'b000)
      $display("FAIL reset_flags: got busy/done/ovf=%b expected 000", {i1.busy, i1.done, i1.ovf});
    else passes++;
    read1(8'd0, 15, 7, s);
    checks++;
    if (s != "-:--:--") $display("FAIL reset_digits: got '%s' expected '-:--:--'", s);
    else passes++;
    i1.char_xy = {8'd15, 8'd1};
    tick();
    checks++;
    if (i1.char_code !== 7'h00) $display("FAIL other_row: got %h expected 00", i1.char_code);
    else passes++;
  endtask

  task automatic test_basic();
    string s;
    int lat;
    i1.mode = 2'd0;
    run1(16'd12345, 200, lat);
    checks++;
    if (lat !== 14) $display("FAIL latency_12345: got %0d expected 14", lat);
    else passes++;
    checks++;
    if (i1.ovf !== 1'b0) $display("FAIL ovf_12345: got %b expected 0", i1.ovf);
    else passes++;
    tick();
    checks++;
    if ({i1.busy, i1.done} !== 2'b00)
      $display("FAIL after_done: got busy/done=%b expected 00", {i1.busy, i1.done});
    else passes++;
    read1(8'd0, 0, 22, s);
    checks++;
    if (s != "BEST LAP TIME: 2:03:45") $display("FAIL line_12345: got '%s' expected 'BEST LAP TIME: 2:03:45'", s);
    else passes++;
  endtask

  task automatic test_bounds();
    string s;
    int lat;
    run1(16'd0, 200, lat);
    checks++;
    if (lat !== 5) $display("FAIL latency_0: got %0d expected 5", lat);
    else passes++;
    read1(8'd0, 15, 7, s);
    checks++;
    if (s != "0:00:00") $display("FAIL digits_0: got '%s' expected '0:00:00'", s);
    else passes++;
    run1(16'd65535, 200, lat);
    checks++;
    if (lat !== 82 || i1.ovf !== 1'b1)
      $display("FAIL sat_65535: got lat=%0d ovf=%b expected lat=82 ovf=1", lat, i1.ovf);
    else passes++;
    read1(8'd0, 15, 7, s);
    checks++;
    if (s != "9:59:99") $display("FAIL digits_65535: got '%s' expected '9:59:99'", s);
    else passes++;
    run1(16'd59999, 200, lat);
    checks++;
    if (lat !== 82 || i1.ovf !== 1'b0)
      $display("FAIL max_59999: got lat=%0d ovf=%b expected lat=82 ovf=0", lat, i1.ovf);
    else passes++;
    run1(16'd60000, 200, lat);
    checks++;
    if (lat !== 82 || i1.ovf !== 1'b1)
      $display("FAIL sat_60000: got lat=%0d ovf=%b expected lat=82 ovf=1", lat, i1.ovf);
    else passes++;
  endtask

  task automatic test_back_to_back();
    string s;
    int dones = 0;
    int first = -1;
    int second = -1;
    logic busy_at_first = 1'b0;
    logic [6:0] min_char = 7'h00;
    i1.char_xy = {8'd15, 8'd0};
    i1.start = 1'b1;
    i1.time_in = 16'd12345;
    tick();
    for (int n = 1; n <= 40; n++) begin
      i1.start = (n == 3 || n == 5);
      i1.time_in = (n == 3) ? 16'd100 : 16'd6000;
      tick();
      if (i1.done === 1'b1) begin
        dones++;
        if (first < 0) begin
          first = n;
          busy_at_first = i1.busy;
        end else if (second < 0) begin
          second = n;
        end
      end
      if (first > 0 && n == first + 1) min_char = i1.char_code;
    end
    checks++;
    if (dones !== 2 || first !== 14 || second !== 20)
      $display("FAIL b2b_pulses: got %0d pulses at %0d,%0d expected 2 at 14,20", dones, first, second);
    else passes++;
    checks++;
    if (busy_at_first !== 1'b1) $display("FAIL b2b_no_idle: got busy=%b expected 1", busy_at_first);
    else passes++;
    checks++;
    if (min_char !== 7'h32) $display("FAIL b2b_first_commit: got %h expected 32", min_char);
    else passes++;
    read1(8'd0, 15, 7, s);
    checks++;
    if (s != "1:00:00") $display("FAIL b2b_second_commit: got '%s' expected '1:00:00'", s);
    else passes++;
  endtask

  task automatic test_reset_mid();
    string s;
    int dones = 0;
    i1.start = 1'b1;
    i1.time_in = 16'd12345;
    tick();
    i1.start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      rst_n = (n == 6) ? 1'b0 : 1'b1;
      tick();
      if (i1.done === 1'b1) dones++;
      if (n == 6) begin
        checks++;
        if (i1.busy !== 1'b0) $display("FAIL mid_reset_busy: got %b expected 0", i1.busy);
        else passes++;
      end
    end
    rst_n = 1'b1;
    checks++;
    if (dones !== 0) $display("FAIL mid_reset_done: got %0d pulses expected 0", dones);
    else passes++;
    read1(8'd0, 15, 7, s);
    checks++;
    if (s != "-:--:--") $display("FAIL mid_reset_digits: got '%s' expected '-:--:--'", s);
    else passes++;
  endtask

  task automatic test_two_digit();
    string s;
    int lat;
    i2.mode = 2'd0;
    run2(20'd359999, 300, lat);
    checks++;
    if (lat !== 132 || i2.ovf !== 1'b0)
      $display("FAIL md2_359999: got lat=%0d ovf=%b expected lat=132 ovf=0", lat, i2.ovf);
    else passes++;
    read2(8'd3, 15, 8, s);
    checks++;
    if (s != "59:59:99") $display("FAIL md2_digits: got '%s' expected '59:59:99'", s);
    else passes++;
    read2(8'd3, 0, 4, s);
    checks++;
    if (s != "BEST") $display("FAIL md2_best: got '%s' expected 'BEST'", s);
    else passes++;
    i2.mode = 2'd1;
    i2.char_xy = {8'd0, 8'd3};
    tick();
    checks++;
    if (i2.char_code !== 7'h4C) $display("FAIL mode_latency: got %h expected 4c", i2.char_code);
    else passes++;
    read2(8'd3, 0, 4, s);
    checks++;
    if (s != "LAST") $display("FAIL md2_last: got '%s' expected 'LAST'", s);
    else passes++;
    read2(8'd3, 15, 8, s);
    checks++;
    if (s != "59:59:99") $display("FAIL md2_digits_kept: got '%s' expected '59:59:99'", s);
    else passes++;
    i2.mode = 2'd2;
    read2(8'd3, 0, 15, s);
    checks++;
    if (s != "LAP TIME     : ") $display("FAIL md2_lap: got '%s' expected 'LAP TIME     : '", s);
    else passes++;
    i2.char_xy = {8'd15, 8'd0};
    tick();
    checks++;
    if (i2.char_code !== 7'h00) $display("FAIL md2_row0: got %h expected 00", i2.char_code);
    else passes++;
    run2(20'd400000, 300, lat);
    checks++;
    if (lat !== 132 || i2.ovf !== 1'b1)
      $display("FAIL md2_400000: got lat=%0d ovf=%b expected lat=132 ovf=1", lat, i2.ovf);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    test_two_digit();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
